// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcode and state encodings plus opcode-field helpers.
package mu0_pkg;

    localparam int OPC_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7,
        OP_OUT = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // The opcode always occupies the top OPC_WIDTH bits of the instruction word.
    function automatic int opc_lsb(input int data_width);
        return data_width - OPC_WIDTH;
    endfunction

    function automatic logic is_mem_op(input logic [OPC_WIDTH-1:0] opc);
        return (opc == OP_LDA) || (opc == OP_STO) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_alu.sv
// Combinational MU0 datapath: pass-through for LDA, modulo add/subtract, ACC flags.
module mu0_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic                  pass_i,
    input  logic                  sub_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  acc_zero_o,
    output logic                  acc_neg_o
);

    always_comb begin
        result_o = acc_i + operand_i;
        if (pass_i) begin
            result_o = operand_i;
        end else if (sub_i) begin
            result_o = acc_i - operand_i;
        end
    end

    assign acc_zero_o = (acc_i == '0);
    assign acc_neg_o  = acc_i[DATA_WIDTH-1];

endmodule

// File: rtl/mu0_cpu_waitreq.sv
// Multi-cycle MU0 CPU with a single stall-aware memory port, OUT port,
// illegal-opcode trap and retired-instruction counter.
module mu0_cpu_waitreq
    import mu0_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-5:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 32,
    localparam int                   ADDR_WIDTH = DATA_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  waitrequest,
    output logic                  running,
    output logic                  illegal,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  retired
);

    localparam int OPC_LSB = opc_lsb(DATA_WIDTH);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   ir_q;
    logic [DATA_WIDTH-1:0]   acc_q;
    logic                    illegal_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [CNT_WIDTH-1:0]    retired_q;

    logic [OPC_WIDTH-1:0]    opc;
    logic [ADDR_WIDTH-1:0]   operand;
    logic                    mem_op;
    logic [DATA_WIDTH-1:0]   acc_d;
    logic [ADDR_WIDTH-1:0]   pc_d;
    logic [CNT_WIDTH-1:0]    retired_d;
    logic                    acc_zero;
    logic                    acc_neg;

    assign opc       = ir_q[OPC_LSB +: OPC_WIDTH];
    assign operand   = ir_q[ADDR_WIDTH-1:0];
    assign mem_op    = is_mem_op(opc);
    assign pc_d      = pc_q + ADDR_WIDTH'(1);
    assign retired_d = retired_q + CNT_WIDTH'(1);

    mu0_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .acc_i     (acc_q),
        .operand_i (readdata),
        .pass_i    (opc == OP_LDA),
        .sub_i     (opc == OP_SUB),
        .result_o  (acc_d),
        .acc_zero_o(acc_zero),
        .acc_neg_o (acc_neg)
    );

    // Port requests decode from registered state only, so they stay put while stalled.
    always_comb begin
        address = pc_q;
        read    = 1'b0;
        write   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: read = 1'b1;
                ST_EXEC: begin
                    if (mem_op) begin
                        address = operand;
                        read    = (opc != OP_STO);
                        write   = (opc == OP_STO);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            acc_q      <= '0;
            illegal_q  <= 1'b0;
            out_data_q <= '0;
            retired_q  <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!waitrequest) begin
                        ir_q    <= readdata;
                        pc_q    <= pc_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opc)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            if (!waitrequest) begin
                                acc_q     <= acc_d;
                                retired_q <= retired_d;
                                state_q   <= ST_FETCH;
                            end
                        end
                        OP_STO: begin
                            if (!waitrequest) begin
                                retired_q <= retired_d;
                                state_q   <= ST_FETCH;
                            end
                        end
                        OP_JMP, OP_JGE, OP_JNE: begin
                            // Jumps overwrite the PC that FETCH already advanced.
                            if ((opc == OP_JMP) ||
                                ((opc == OP_JGE) && !acc_neg) ||
                                ((opc == OP_JNE) && !acc_zero)) begin
                                pc_q <= operand;
                            end
                            retired_q <= retired_d;
                            state_q   <= ST_FETCH;
                        end
                        OP_OUT: begin
                            out_data_q <= acc_q;
                            retired_q  <= retired_d;
                            state_q    <= ST_FETCH;
                        end
                        OP_STP: begin
                            retired_q <= retired_d;
                            state_q   <= ST_HALTED;
                        end
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= ST_HALTED;
                        end
                    endcase
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

    assign writedata = acc_q;
    assign running   = (state_q != ST_HALTED);
    assign illegal   = illegal_q;
    assign out_valid = (state_q == ST_EXEC) && (opc == OP_OUT);
    assign out_data  = out_data_q;
    assign retired   = retired_q;

endmodule
